seq_checker: RTL and testbench



---
 rtl/seq_checker.sv | 139 +++++++++++++
 tb/tb_seq_checker.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/seq_checker.sv
// rtl/seq_checker.sv - receive-end sequence checker for the 4-bit D-FF counter (optional SEQ_CHECK_POS_EN)
module seq_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    output logic             locked,
    output logic             err,
    output logic             illegal,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       pos
);

    typedef enum logic [1:0] {EMPTY, TRACK, LOCKED} state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

    state_t           state, state_nxt;
    logic [3:0]       code, prev, prev_nxt, match_cnt, match_nxt, match_inc;
    logic             locked_nxt, err_nxt, illegal_nxt;
    logic [CNT_W-1:0] err_cnt_nxt, err_cnt_inc;

    assign code = {d, c, b, a};

    // Unused codes fall through to 0000, which never matches a successor check.
    function automatic logic [3:0] succ(input logic [3:0] x);
        case (x)
            4'b0000: succ = 4'b0111;
            4'b0111: succ = 4'b0011;
            4'b0011: succ = 4'b0101;
            4'b0101: succ = 4'b1001;
            4'b1001: succ = 4'b1000;
            4'b1000: succ = 4'b1011;
            4'b1011: succ = 4'b1010;
            4'b1010: succ = 4'b0110;
            4'b0110: succ = 4'b0100;
            4'b0100: succ = 4'b0111;
            default: succ = 4'b0000;
        endcase
    endfunction

    function automatic logic is_illegal(input logic [3:0] x);
        is_illegal = (x == 4'b0001) || (x == 4'b0010) || (x[3:2] == 2'b11);
    endfunction

    assign err_cnt_inc = (err_cnt == {CNT_W{1'b1}}) ? err_cnt
                                                    : err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    assign match_inc   = (match_cnt == LOCK_N) ? match_cnt : match_cnt + 4'd1;

    always_comb begin
        state_nxt   = state;
        prev_nxt    = prev;
        match_nxt   = match_cnt;
        locked_nxt  = locked;
        err_nxt     = 1'b0;
        illegal_nxt = 1'b0;
        err_cnt_nxt = err_cnt;
        if (sample_en) begin
            if (is_illegal(code)) begin
                err_nxt     = 1'b1;
                illegal_nxt = 1'b1;
                err_cnt_nxt = err_cnt_inc;
                match_nxt   = 4'd0;
                locked_nxt  = 1'b0;
                state_nxt   = EMPTY;
            end else if (state == EMPTY) begin
                prev_nxt  = code;
                match_nxt = 4'd0;
                state_nxt = TRACK;
            end else if (code == succ(prev)) begin
                prev_nxt  = code;
                match_nxt = match_inc;
                if (match_inc == LOCK_N) begin
                    state_nxt  = LOCKED;
                    locked_nxt = 1'b1;
                end
            end else begin
                // Legal but out of order: resync on this sample and start counting again.
                err_nxt     = 1'b1;
                err_cnt_nxt = err_cnt_inc;
                match_nxt   = 4'd0;
                prev_nxt    = code;
                locked_nxt  = 1'b0;
                state_nxt   = TRACK;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            prev      <= 4'b0000;
            match_cnt <= 4'd0;
            locked    <= 1'b0;
            err       <= 1'b0;
            illegal   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            prev      <= prev_nxt;
            match_cnt <= match_nxt;
            locked    <= locked_nxt;
            err       <= err_nxt;
            illegal   <= illegal_nxt;
            err_cnt   <= err_cnt_nxt;
        end
    end

`ifdef SEQ_CHECK_POS_EN
    function automatic logic [3:0] cycle_idx(input logic [3:0] x);
        case (x)
            4'b0111: cycle_idx = 4'd0;
            4'b0011: cycle_idx = 4'd1;
            4'b0101: cycle_idx = 4'd2;
            4'b1001: cycle_idx = 4'd3;
            4'b1000: cycle_idx = 4'd4;
            4'b1011: cycle_idx = 4'd5;
            4'b1010: cycle_idx = 4'd6;
            4'b0110: cycle_idx = 4'd7;
            4'b0100: cycle_idx = 4'd8;
            default: cycle_idx = 4'hF;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pos <= 4'hF;
        else       pos <= locked_nxt ? cycle_idx(prev_nxt) : 4'hF;
    end
`else
    assign pos = 4'hF;
`endif

endmodule

// File: tb/tb_seq_checker.sv
// tb/tb_seq_checker.sv - directed self-checking bench for seq_checker
module tb_seq_checker;

`ifdef SEQ_CHECK_POS_EN
    localparam bit POS_EN = 1'b1;
`else
    localparam bit POS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_en;
    logic       a, b, c, d;
    logic       locked, err, illegal;
    logic [7:0] err_cnt;
    logic [3:0] pos;
    logic       s_locked, s_err, s_illegal;
    logic [1:0] s_err_cnt;
    logic [3:0] s_pos;

    int n_checks = 0;
    int n_pass   = 0;
    int err_seen = 0;

    always #5 clk = ~clk;

    seq_checker #(.LOCK_COUNT(4), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .sample_en(sample_en),
        .a(a), .b(b), .c(c), .d(d),
        .locked(locked), .err(err), .illegal(illegal), .err_cnt(err_cnt), .pos(pos)
    );

    seq_checker #(.LOCK_COUNT(4), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .sample_en(sample_en),
        .a(a), .b(b), .c(c), .d(d),
        .locked(s_locked), .err(s_err), .illegal(s_illegal), .err_cnt(s_err_cnt), .pos(s_pos)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic feed(input logic [3:0] code, input logic en);
        {d, c, b, a} = code;
        sample_en    = en;
        @(posedge clk);
        #1;
        if (err) err_seen++;
    endtask

    function automatic logic [3:0] pexp(input logic [3:0] p);
        return POS_EN ? p : 4'hF;
    endfunction

    initial begin
        reset = 1'b1; sample_en = 1'b0; {d, c, b, a} = 4'b0000;
        #12;
        check("rst_locked", locked, 0);
        check("rst_err", err, 0);
        check("rst_illegal", illegal, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_pos", pos, 4'hF);
        reset = 1'b0;

        // Lock on the first four good transitions
        err_seen = 0;
        feed(4'b0000, 1); feed(4'b0111, 1); feed(4'b0011, 1); feed(4'b0101, 1);
        check("prelock_locked", locked, 0);
        feed(4'b1001, 1);
        check("lock1_locked", locked, 1);
        check("lock1_err_seen", err_seen, 0);
        check("lock1_err_cnt", err_cnt, 0);
        check("lock1_pos", pos, pexp(4'd3));

        // Legal mismatch while locked, then relock from the new reference
        feed(4'b0110, 1);
        check("mis_err", err, 1);
        check("mis_illegal", illegal, 0);
        check("mis_err_cnt", err_cnt, 1);
        check("mis_locked", locked, 0);
        check("mis_pos", pos, 4'hF);
        err_seen = 0;
        feed(4'b0100, 1); feed(4'b0111, 1); feed(4'b0011, 1);
        check("relock_pre", locked, 0);
        feed(4'b0101, 1);
        check("relock_locked", locked, 1);
        check("relock_err_cnt", err_cnt, 1);
        check("relock_err_seen", err_seen, 0);
        check("relock_pos", pos, pexp(4'd2));

        // Repeated sample is a mismatch, then an illegal code from TRACK
        feed(4'b0101, 1);
        check("rep_err", err, 1);
        check("rep_locked", locked, 0);
        check("rep_err_cnt", err_cnt, 2);
        feed(4'b1111, 1);
        check("ill_err", err, 1);
        check("ill_illegal", illegal, 1);
        check("ill_err_cnt", err_cnt, 3);
        err_seen = 0;
        feed(4'b0111, 1);
        check("empty_entry_err", err, 0);
        check("empty_entry_illegal", illegal, 0);
        feed(4'b0011, 1); feed(4'b0101, 1); feed(4'b1001, 1);
        check("track_pre", locked, 0);
        feed(4'b1000, 1);
        check("track_locked", locked, 1);
        check("track_err_seen", err_seen, 0);
        check("track_pos", pos, pexp(4'd4));

        // Disabled sampling holds state and suppresses err
        feed(4'b1101, 0);
        check("hold_err", err, 0);
        check("hold_illegal", illegal, 0);
        check("hold_locked", locked, 1);
        check("hold_err_cnt", err_cnt, 3);

        // Asynchronous reset between edges
        #2 reset = 1'b1;
        #1;
        check("arst_locked", locked, 0);
        check("arst_err_cnt", err_cnt, 0);
        check("arst_pos", pos, 4'hF);
        reset = 1'b0;

        // Interleaved disabled cycles carrying garbage
        err_seen = 0;
        feed(4'b0000, 1); feed(4'b1101, 0);
        feed(4'b0111, 1); feed(4'b1101, 0);
        feed(4'b0011, 1); feed(4'b1101, 0);
        feed(4'b0101, 1); feed(4'b1101, 0);
        check("gap_pre", locked, 0);
        feed(4'b1001, 1);
        check("gap_locked", locked, 1);
        check("gap_err_seen", err_seen, 0);
        check("gap_err_cnt", err_cnt, 0);

        // Error counter saturation on the narrow instance
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        err_seen = 0;
        feed(4'b0001, 1); feed(4'b0010, 1); feed(4'b1100, 1); feed(4'b1101, 1);
        check("sat_mid", s_err_cnt, 3);
        feed(4'b1110, 1);
        check("sat_pulses", err_seen, 5);
        check("sat_err_cnt", s_err_cnt, 3);
        check("sat_wide_cnt", err_cnt, 5);
        check("sat_illegal", s_illegal, 1);
        feed(4'b0000, 0);
        check("sat_err_clear", s_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
